// File: rtl/tt_sweep_capture_if.sv
// Bundle between the sweep engine and whoever drives it: control, expected
// table, the 7-bit pattern drive, the function output f, and the results.
interface tt_sweep_capture_if;
   logic         start;
   logic         abort;
   logic [127:0] tt_exp;
   logic         x0, x1, x2, x3, x4, x5, x6;
   logic         f;
   logic         busy;
   logic         done;
   logic [127:0] tt_out;
   logic         match;
   logic [7:0]   mis_cnt;
   logic [6:0]   first_mis;
   logic [1:0]   dbg_state;

   modport master (
      output start, abort, tt_exp, f,
      input  x0, x1, x2, x3, x4, x5, x6,
      input  busy, done, tt_out, match, mis_cnt, first_mis, dbg_state
   );

   modport slave (
      input  start, abort, tt_exp, f,
      output x0, x1, x2, x3, x4, x5, x6,
      output busy, done, tt_out, match, mis_cnt, first_mis, dbg_state
   );
endinterface

// File: rtl/tt_sweep_capture.sv
// Drives all 128 input patterns into a 7-input function, captures its truth
// table and compares it against an expected table latched at start.
module tt_sweep_capture #(
   parameter int unsigned SETTLE = 0
) (
   input logic             clk,
   input logic             rst,
   tt_sweep_capture_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_L = 4'(SETTLE);

   state_t       state;
   logic [6:0]   idx;
   logic [6:0]   pat;
   logic [3:0]   wait_cnt;
   logic [127:0] exp_lat;
   logic [127:0] tt_out;
   logic [7:0]   mis_cnt;
   logic [6:0]   first_mis;
   logic         busy;
   logic         done;
   logic         match;
   logic         mis_now;

   assign mis_now = (bus.f != exp_lat[idx]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         pat       <= '0;
         wait_cnt  <= '0;
         exp_lat   <= '0;
         tt_out    <= '0;
         mis_cnt   <= '0;
         first_mis <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         match     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               pat <= '0;
               // abort dominates a simultaneous start
               if (bus.start && !bus.abort) begin
                  state     <= RUN;
                  busy      <= 1'b1;
                  idx       <= '0;
                  wait_cnt  <= '0;
                  exp_lat   <= bus.tt_exp;
                  tt_out    <= '0;
                  mis_cnt   <= '0;
                  first_mis <= '0;
                  match     <= 1'b0;
               end
            end
            RUN: begin
               if (bus.abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  match <= 1'b0;
                  pat   <= '0;
               end else if (wait_cnt == SETTLE_L) begin
                  tt_out[idx] <= bus.f;
                  wait_cnt    <= '0;
                  if (mis_now) begin
                     mis_cnt <= mis_cnt + 8'd1;
                     if (mis_cnt == 8'd0) first_mis <= idx;
                  end
                  if (idx == 7'd127) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pat   <= '0;
                     // include the final sample, whose count update is not yet visible
                     match <= (mis_cnt == 8'd0) && !mis_now;
                  end else begin
                     idx <= idx + 7'd1;
                     pat <= idx + 7'd1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            DONE: begin
               state <= IDLE;
               pat   <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.x0        = pat[0];
   assign bus.x1        = pat[1];
   assign bus.x2        = pat[2];
   assign bus.x3        = pat[3];
   assign bus.x4        = pat[4];
   assign bus.x5        = pat[5];
   assign bus.x6        = pat[6];
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.tt_out    = tt_out;
   assign bus.match     = match;
   assign bus.mis_cnt   = mis_cnt;
   assign bus.first_mis = first_mis;
   assign bus.dbg_state = state;
endmodule
